// File: rtl/gate_pkg.sv
// Shared types, fail_mask bit positions and the golden truth table for the
// gate library self-test.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NAND_B = 4;
  localparam int INV_B  = 3;
  localparam int AND_B  = 2;
  localparam int OR_B   = 1;
  localparam int XOR_B  = 0;

  function automatic logic [4:0] expected_gates(input logic a, input logic b);
    logic [4:0] g;
    g         = '0;
    g[NAND_B] = ~(a & b);
    g[INV_B]  = ~a;
    g[AND_B]  = a & b;
    g[OR_B]   = a | b;
    g[XOR_B]  = a ^ b;
    return g;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational golden model: the five gate results a correct block must
// produce for the operands currently being driven.
module gate_expect
  import gate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [4:0] expected
);

  assign expected = expected_gates(a, b);

endmodule

// File: rtl/gate_selftest.sv
// Self-test sequencer: sweeps {a,b} through 00..11, waits for the gate block
// to settle, compares its outputs with the golden model and reports results.
module gate_selftest
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       out_nand,
  input  logic       out_inv,
  input  logic       out_and,
  input  logic       out_or,
  input  logic       out_xor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_vec
);

  // start is a level request accepted only in IDLE; busy is the not-ready
  // indication (start is ignored while it is high or during DONE), and done
  // pulses exactly once per accepted start.

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [4:0] expected;
  logic [4:0] observed;
  logic [4:0] mismatch;

  gate_expect u_expect (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign observed = {out_nand, out_inv, out_and, out_or, out_xor};
  assign mismatch = observed ^ expected;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = (vec == 2'd3) ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec            <= '0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec            <= '0;
            cnt            <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
          end
        end
        SETTLE: cnt <= cnt + 4'd1;
        SAMPLE: begin
          fail_mask <= fail_mask | mismatch;
          if (mismatch != 5'd0) begin
            err_count <= err_count + 3'd1;
            if (err_count == 3'd0) first_fail_vec <= vec;
          end
          // pass uses the mask including this final vector's merge
          if (vec == 2'd3) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= ((fail_mask | mismatch) == 5'd0);
          end else begin
            vec    <= vec + 2'd1;
            {a, b} <= vec + 2'd1;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: a fault-injectable gate block model feeds two DUT
// instances (SETTLE_CYCLES=2 and 1); sweep results are scoreboarded.
module tb_gate_selftest;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  wire  [1:0] a_o, b_o, busy_o, done_o, pass_o;
  wire  [4:0] mask_o [2];
  wire  [2:0] errc_o [2];
  wire  [1:0] ffv_o  [2];
  logic [4:0] gates0, gates1;

  int         fault_mode;
  logic [4:0] flip_tbl [4];
  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  // Gate block model; bits ordered {nand, inv, and, or, xor}
  function automatic logic [4:0] gate_block(input int mode, input logic a, input logic b,
                                            input logic [4:0] flip);
    logic [4:0] g;
    g = {~(a & b), ~a, a & b, a | b, a ^ b};
    case (mode)
      1: g[0] = 1'b0;
      2: g[3] = ~b;
      3: begin g[4] = 1'b1; g[1] = 1'b1; end
      4: g = g ^ flip;
      default: ;
    endcase
    return g;
  endfunction

  always_comb gates0 = gate_block(fault_mode, a_o[0], b_o[0], flip_tbl[{a_o[0], b_o[0]}]);
  always_comb gates1 = gate_block(fault_mode, a_o[1], b_o[1], flip_tbl[{a_o[1], b_o[1]}]);

  gate_selftest #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_o[0]), .b(b_o[0]),
    .out_nand(gates0[4]), .out_inv(gates0[3]), .out_and(gates0[2]),
    .out_or(gates0[1]), .out_xor(gates0[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .fail_mask(mask_o[0]), .err_count(errc_o[0]), .first_fail_vec(ffv_o[0])
  );

  gate_selftest #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_o[1]), .b(b_o[1]),
    .out_nand(gates1[4]), .out_inv(gates1[3]), .out_and(gates1[2]),
    .out_or(gates1[1]), .out_xor(gates1[0]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .fail_mask(mask_o[1]), .err_count(errc_o[1]), .first_fail_vec(ffv_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Truth tables indexed by {a,b}
  function automatic logic [4:0] ideal_gates(input logic [1:0] v);
    logic [3:0] nand_t = 4'b0111;
    logic [3:0] inv_t  = 4'b0011;
    logic [3:0] and_t  = 4'b1000;
    logic [3:0] or_t   = 4'b1110;
    logic [3:0] xor_t  = 4'b0110;
    return {nand_t[v], inv_t[v], and_t[v], or_t[v], xor_t[v]};
  endfunction

  // Expected {pass, fail_mask, err_count, first_fail_vec} for a whole sweep
  function automatic logic [10:0] model_sweep(input int mode);
    logic [4:0] mask = '0;
    logic [4:0] m;
    logic [2:0] errs = '0;
    logic [1:0] ffv = '0;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      m = gate_block(mode, v[1], v[0], flip_tbl[v]) ^ ideal_gates(v);
      if (m != 5'd0) begin
        if (errs == 3'd0) ffv = v;
        errs = errs + 3'd1;
      end
      mask = mask | m;
    end
    return {(mask == 5'd0), mask, errs, ffv};
  endfunction

  task automatic run_sweep(input int inst, input int sc, input int mode, input bit hold);
    bit          seen = 1'b0;
    int          last;
    logic [10:0] got = '0;
    fault_mode = mode;
    exp_q.push_back(model_sweep(mode));
    last = 1 + 4 * (sc + 1);
    @(negedge clk);
    start[inst] = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (!hold) start[inst] = 1'b0;
      if (done_o[inst]) begin
        seen = 1'b1;
        start[inst] = 1'b0;
        got = {pass_o[inst], mask_o[inst], errc_o[inst], ffv_o[inst]};
        check("done_cycle", k, last);
        check("busy_in_done", busy_o[inst], 0);
        check("ab_final", {a_o[inst], b_o[inst]}, 3);
        check("result", got, exp_q.pop_front());
      end else begin
        check("busy", busy_o[inst], 1);
        check("ab_seq", {a_o[inst], b_o[inst]}, (k - 1) / (sc + 1));
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
      start[inst] = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("done_single", done_o[inst], 0);
      check("busy_idle", busy_o[inst], 0);
      check("result_hold", {pass_o[inst], mask_o[inst], errc_o[inst], ffv_o[inst]}, got);
    end
  endtask

  task automatic check_cleared(input int inst);
    check("rst_busy", busy_o[inst], 0);
    check("rst_done", done_o[inst], 0);
    check("rst_pass", pass_o[inst], 0);
    check("rst_ab", {a_o[inst], b_o[inst]}, 0);
    check("rst_mask", mask_o[inst], 0);
    check("rst_errc", errc_o[inst], 0);
    check("rst_ffv", ffv_o[inst], 0);
  endtask

  task automatic reset_mid_sweep();
    fault_mode = 3;
    @(negedge clk);
    start[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    check("pre_rst_ab", {a_o[0], b_o[0]}, 2'b10);
    check("pre_rst_mask", mask_o[0], 5'b00010);
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared(0);
    check("rst_state", 32'(u_dut0.state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy_o[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 2'b00;
    fault_mode = 0;
    for (int i = 0; i < 4; i++) flip_tbl[i] = '0;
    repeat (3) @(negedge clk);
    check_cleared(0);
    check_cleared(1);
    rst_n = 1'b1;

    run_sweep(0, 2, 0, 1'b0);
    run_sweep(0, 2, 1, 1'b0);
    run_sweep(0, 2, 2, 1'b0);
    run_sweep(0, 2, 3, 1'b0);
    reset_mid_sweep();
    run_sweep(0, 2, 0, 1'b0);
    run_sweep(1, 1, 0, 1'b1);
    run_sweep(1, 1, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int inst;
      for (int i = 0; i < 4; i++) flip_tbl[i] = 5'($urandom_range(0, 31));
      inst = $urandom_range(0, 1);
      run_sweep(inst, (inst == 0) ? 2 : 1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
